// File: rtl/memsync_pkg.sv
// memsync_pkg -- shared definitions for the MEMSync row-transfer path.
//   rowsync_state_t : row_sync_engine FSM states
//   COLS            : beats per row at the default column width
//   MS_*            : MEMSync controller state encodings, kept here so that
//                     engines and benches agree on the handshake side.
package memsync_pkg;

    typedef enum logic [2:0] {
        RS_IDLE  = 3'd0,
        RS_AL_RD = 3'd1,
        RS_AL_WR = 3'd2,
        RS_WB_RD = 3'd3,
        RS_WB_WR = 3'd4,
        RS_DONE  = 3'd5,
        RS_HOLD  = 3'd6
    } rowsync_state_t;

    localparam int unsigned COLWIDTH_DEF = 5;
    localparam int unsigned COLS         = 1 << COLWIDTH_DEF;

    // MEMSync controller encodings
    localparam logic [2:0] MS_IDLE       = 3'd0;
    localparam logic [2:0] MS_ALLOCATE   = 3'd1;
    localparam logic [2:0] MS_COMPARETAG = 3'd2;
    localparam logic [2:0] MS_UPDATETAG  = 3'd3;
    localparam logic [2:0] MS_WRITEBACK  = 3'd4;
    localparam logic [2:0] MS_HITRD      = 3'd5;
    localparam logic [2:0] MS_HITWR      = 3'd6;

endpackage

// File: rtl/row_sync_engine.sv
// row_sync_engine -- moves one full row between backing memory and the
// channel row cache while MEMSync sits in WriteBack or Allocate, then pulses
// sync for one cycle.
//
// Ports:
//   clk, rst            clock / synchronous active-low reset
//   wb_req, alloc_req   MEMSync state levels (WriteBack / Allocate)
//   cRowId, RowId,      cache row, allocate source row, writeback victim row
//   wbRowId
//   sync, busy          completion pulse / transfer in progress
//   c_addr,c_rd,c_wr,   row-cache port (c_rdata valid the cycle after c_rd)
//   c_wdata,c_rdata
//   m_addr,m_req,m_we,  backing-memory port (m_rdata valid the cycle after an
//   m_ready,m_wdata,    accepted read)
//   m_rdata
//   wb_cnt, al_cnt,     completed-transfer and stall counters
//   stall_cnt
//
// Build option: define ROWSYNC_CNT_EN to generate the counters; otherwise the
// counter outputs are tied to zero.
module row_sync_engine
    import memsync_pkg::*;
#(
    parameter int CHWIDTH   = 6,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 5,
    parameter int DWIDTH    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_req,
    input  logic                          alloc_req,
    input  logic [CHWIDTH-1:0]            cRowId,
    input  logic [ADDRWIDTH-1:0]          RowId,
    input  logic [ADDRWIDTH-1:0]          wbRowId,
    output logic                          sync,
    output logic                          busy,
    output logic [CHWIDTH+COLWIDTH-1:0]   c_addr,
    output logic                          c_rd,
    output logic                          c_wr,
    output logic [DWIDTH-1:0]             c_wdata,
    input  logic [DWIDTH-1:0]             c_rdata,
    output logic [ADDRWIDTH+COLWIDTH-1:0] m_addr,
    output logic                          m_req,
    output logic                          m_we,
    input  logic                          m_ready,
    output logic [DWIDTH-1:0]             m_wdata,
    input  logic [DWIDTH-1:0]             m_rdata,
    output logic [31:0]                   wb_cnt,
    output logic [31:0]                   al_cnt,
    output logic [31:0]                   stall_cnt
);

    rowsync_state_t         r_state;
    logic [COLWIDTH-1:0]    r_col;
    logic [CHWIDTH-1:0]     r_crow;
    logic [ADDRWIDTH-1:0]   r_row;
    logic [ADDRWIDTH-1:0]   r_wbrow;
    logic                   r_is_wb;
    logic                   r_wr_first;   // first cycle of WB_WR: c_rdata is live
    logic [DWIDTH-1:0]      r_wdata;      // c_rdata captured for stalled WB_WR cycles
    logic                   w_last_col;

    assign w_last_col = &r_col;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= RS_IDLE;
            r_col      <= '0;
            r_crow     <= '0;
            r_row      <= '0;
            r_wbrow    <= '0;
            r_is_wb    <= 1'b0;
            r_wr_first <= 1'b0;
            r_wdata    <= '0;
        end else begin
            case (r_state)
                RS_IDLE: begin
                    r_col <= '0;
                    // wb_req wins if MEMSync ever raises both
                    if (wb_req || alloc_req) begin
                        r_crow  <= cRowId;
                        r_row   <= RowId;
                        r_wbrow <= wbRowId;
                        r_is_wb <= wb_req;
                        r_state <= wb_req ? RS_WB_RD : RS_AL_RD;
                    end
                end
                RS_AL_RD: begin
                    if (m_ready) r_state <= RS_AL_WR;
                end
                RS_AL_WR: begin
                    if (w_last_col) begin
                        r_state <= RS_DONE;
                    end else begin
                        r_col   <= r_col + COLWIDTH'(1);
                        r_state <= RS_AL_RD;
                    end
                end
                RS_WB_RD: begin
                    r_wr_first <= 1'b1;
                    r_state    <= RS_WB_WR;
                end
                RS_WB_WR: begin
                    // hold the read data so m_wdata stays stable across stalls
                    if (r_wr_first) begin
                        r_wdata    <= c_rdata;
                        r_wr_first <= 1'b0;
                    end
                    if (m_ready) begin
                        if (w_last_col) begin
                            r_state <= RS_DONE;
                        end else begin
                            r_col   <= r_col + COLWIDTH'(1);
                            r_state <= RS_WB_RD;
                        end
                    end
                end
                RS_DONE: r_state <= RS_HOLD;
                // MEMSync drops its request the cycle after sync; skip it
                RS_HOLD: r_state <= RS_IDLE;
                default: r_state <= RS_IDLE;
            endcase
        end
    end

    always_comb begin
        sync    = 1'b0;
        busy    = 1'b0;
        c_addr  = '0;
        c_rd    = 1'b0;
        c_wr    = 1'b0;
        c_wdata = '0;
        m_addr  = '0;
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_wdata = '0;
        case (r_state)
            RS_AL_RD: begin
                busy   = 1'b1;
                m_req  = 1'b1;
                m_addr = {r_row, r_col};
            end
            RS_AL_WR: begin
                busy    = 1'b1;
                c_wr    = 1'b1;
                c_addr  = {r_crow, r_col};
                c_wdata = m_rdata;
            end
            RS_WB_RD: begin
                busy   = 1'b1;
                c_rd   = 1'b1;
                c_addr = {r_crow, r_col};
            end
            RS_WB_WR: begin
                busy    = 1'b1;
                m_req   = 1'b1;
                m_we    = 1'b1;
                m_addr  = {r_wbrow, r_col};
                m_wdata = r_wr_first ? c_rdata : r_wdata;
            end
            RS_DONE: begin
                busy = 1'b1;
                sync = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef ROWSYNC_CNT_EN
    logic [31:0] r_wb_cnt;
    logic [31:0] r_al_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wb_cnt    <= '0;
            r_al_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_state == RS_DONE) begin
                if (r_is_wb) r_wb_cnt <= r_wb_cnt + 32'd1;
                else         r_al_cnt <= r_al_cnt + 32'd1;
            end
            if (m_req && !m_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign wb_cnt    = r_wb_cnt;
    assign al_cnt    = r_al_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    assign wb_cnt    = '0;
    assign al_cnt    = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_row_sync_engine.sv
// Scoreboard bench for row_sync_engine at COLWIDTH=2 (4 beats per row).
// Stimulus pushes expected cache writes, backing writes and sync cycles; a
// negedge monitor pops and compares as the DUT presents them.
module tb_row_sync_engine;

    localparam int CHW = 6;
    localparam int AW  = 17;
    localparam int CW  = 2;
    localparam int DW  = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic                wb_req, alloc_req;
    logic [CHW-1:0]      cRowId;
    logic [AW-1:0]       RowId, wbRowId;
    logic                sync, busy;
    logic [CHW+CW-1:0]   c_addr;
    logic                c_rd, c_wr;
    logic [DW-1:0]       c_wdata, c_rdata;
    logic [AW+CW-1:0]    m_addr;
    logic                m_req, m_we, m_ready;
    logic [DW-1:0]       m_wdata, m_rdata;
    logic [31:0]         wb_cnt, al_cnt, stall_cnt;

    row_sync_engine #(.CHWIDTH(CHW), .ADDRWIDTH(AW), .COLWIDTH(CW), .DWIDTH(DW)) dut (
        .clk(clk), .rst(rst), .wb_req(wb_req), .alloc_req(alloc_req),
        .cRowId(cRowId), .RowId(RowId), .wbRowId(wbRowId),
        .sync(sync), .busy(busy),
        .c_addr(c_addr), .c_rd(c_rd), .c_wr(c_wr), .c_wdata(c_wdata), .c_rdata(c_rdata),
        .m_addr(m_addr), .m_req(m_req), .m_we(m_we), .m_ready(m_ready),
        .m_wdata(m_wdata), .m_rdata(m_rdata),
        .wb_cnt(wb_cnt), .al_cnt(al_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          kind;   // 0 cache write, 1 backing write, 2 sync (data = cycle)
        logic [31:0] addr;
        logic [63:0] data;
    } ev_t;
    ev_t sbq[$];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(int k, logic [31:0] a, logic [63:0] d);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d;
        sbq.push_back(e);
    endtask

    task automatic observe(int k, logic [31:0] a, logic [63:0] d, string nm);
        ev_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s unexpected: addr %h data %h, required no event (cycle %0d)", nm, a, d, cyc);
        end else begin
            e = sbq.pop_front();
            chk({nm, "_kind"}, 64'(k), 64'(e.kind));
            chk({nm, "_addr"}, 64'(a), 64'(e.addr));
            chk({nm, "_data"}, d, e.data);
        end
    endtask

    // simple memory models: read data appears the cycle after the request
    logic          p_mrd, p_crd;
    logic [CW-1:0] p_mcol, p_ccol;
    always @(negedge clk) begin
        p_mrd  = m_req && m_ready && !m_we;
        p_mcol = m_addr[CW-1:0];
        p_crd  = c_rd;
        p_ccol = c_addr[CW-1:0];
    end
    always @(posedge clk) begin
        if (p_mrd) m_rdata <= 64'h10 + 64'(p_mcol);
        if (p_crd) c_rdata <= 64'hA0 + 64'(p_ccol);
    end

    // monitor
    always @(negedge clk) begin
        if (c_wr)                     observe(0, 32'(c_addr), c_wdata, "cache_wr");
        if (m_req && m_ready && m_we) observe(1, 32'(m_addr), m_wdata, "mem_wr");
        if (sync)                     observe(2, 32'd0, 64'(cyc), "sync");
        if ((c_rd || c_wr) && m_req)  chk("port_excl", 64'(1), 64'(0));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sync(int max);
        for (int i = 0; i < max && !sync; i++) step();
        if (!sync) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sync_timeout: got no sync, required sync within %0d cycles", max);
        end
    endtask

    task automatic finish_xfer();
        step();                      // HOLD
        wb_req    = 1'b0;
        alloc_req = 1'b0;
        step();                      // IDLE
    endtask

    task automatic push_alloc(int crow, int t_sync);
        for (int c = 0; c < 4; c++) push(0, 32'((crow << CW) | c), 64'h10 + 64'(c));
        if (t_sync >= 0) push(2, 32'd0, 64'(t_sync));
    endtask

    task automatic push_wb(int row, int t_sync);
        for (int c = 0; c < 4; c++) push(1, 32'((row << CW) | c), 64'hA0 + 64'(c));
        push(2, 32'd0, 64'(t_sync));
    endtask

    task automatic chk_idle_outs(string nm);
        chk({nm, "_ctrl"}, 64'({sync, busy, c_rd, c_wr, m_req, m_we}), 64'(0));
        chk({nm, "_addr"}, 64'({c_addr, m_addr}), 64'(0));
        chk({nm, "_data"}, c_wdata | m_wdata, 64'(0));
    endtask

    int t0, s;

    initial begin
        rst = 1'b0; wb_req = 1'b1; alloc_req = 1'b1; m_ready = 1'b1;
        cRowId = '0; RowId = '0; wbRowId = '0;
        m_rdata = '0; c_rdata = '0;

        // reset with requests high
        step(); chk_idle_outs("rst_c1");
        step(); chk_idle_outs("rst_c2");
        wb_req = 1'b0; alloc_req = 1'b0; rst = 1'b1;
        step();

        // allocate
        alloc_req = 1'b1; RowId = 17'h1ABCD; cRowId = 6'd5; t0 = cyc;
        push_alloc(5, t0 + 9);
        step(); chk("al_busy_c1", 64'(busy), 64'(1));
        chk("al_maddr_c1", 64'(m_addr), 64'({17'h1ABCD, 2'd0}));
        wait_sync(40); finish_xfer();

        // writeback
        wb_req = 1'b1; cRowId = 6'd3; wbRowId = 17'h00042; t0 = cyc;
        push_wb(17'h42, t0 + 9);
        step(); chk("wb_crd_c1", 64'({busy, c_rd}), 64'(2'b11));
        wait_sync(40); finish_xfer();

        // backpressure: beat 1 stalls three cycles
        alloc_req = 1'b1; RowId = 17'h00F0F; cRowId = 6'd9; t0 = cyc;
        push_alloc(9, t0 + 12);
        step(); step(); step();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", 64'({m_req, m_we}), 64'(2'b10));
            chk("stall_addr", 64'(m_addr), 64'({17'h00F0F, 2'd1}));
            step();
        end
        m_ready = 1'b1;
        chk("stall_addr_end", 64'(m_addr), 64'({17'h00F0F, 2'd1}));
        wait_sync(40); finish_xfer();

        // writeback then allocate
        wb_req = 1'b1; cRowId = 6'd7; wbRowId = 17'h00100; RowId = 17'h1FFFF; t0 = cyc;
        push_wb(17'h100, t0 + 9);
        wait_sync(40);
        s = cyc;
        step();
        wb_req = 1'b0; alloc_req = 1'b1;
        push_alloc(7, s + 11);
        step(); chk("gap_idle_busy", 64'(busy), 64'(0));
        step(); chk("gap_start_busy", 64'(busy), 64'(1));
        chk("gap_start_addr", 64'(m_addr), 64'({17'h1FFFF, 2'd0}));
        wait_sync(40); finish_xfer();

        // reset mid-allocate (in cycle 4), then a clean allocate
        alloc_req = 1'b1; RowId = 17'h00777; cRowId = 6'd2; t0 = cyc;
        push(0, 32'((2 << CW) | 0), 64'h10);
        push(0, 32'((2 << CW) | 1), 64'h11);
        step(); step(); step(); step();
        rst = 1'b0;
        step();
        chk_idle_outs("rst_mid");
        rst = 1'b1; alloc_req = 1'b0;
        step();
        alloc_req = 1'b1; RowId = 17'h12345; cRowId = 6'd4; t0 = cyc;
        push_alloc(4, t0 + 9);
        wait_sync(40); finish_xfer();

        step(); step();
        chk("sb_empty", 64'(sbq.size()), 64'(0));
`ifdef ROWSYNC_CNT_EN
        // reset also clears counters: only the post-reset allocate remains
        chk("al_cnt", 64'(al_cnt), 64'(1));
        chk("wb_cnt", 64'(wb_cnt), 64'(0));
        chk("stall_cnt", 64'(stall_cnt), 64'(0));
`else
        chk("cnt_tied", 64'(al_cnt | wb_cnt | stall_cnt), 64'(0));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/row_sync_engine.md
# row_sync_engine

Row-transfer engine on the far side of the MEMSync `sync` handshake. It moves a full row between backing memory and the channel row cache whenever MEMSync sits in WriteBack or Allocate, then pulses `sync` to release it. Placement: one instance per channel, between MEMSync and the backing-memory port.

## Interface
- `CHWIDTH`, default 6: cache row index width (2^CHWIDTH cache rows).
- `ADDRWIDTH`, default 17: backing row address width.
- `COLWIDTH`, default 5: column index width; COLS = 2^COLWIDTH beats per row.
- `DWIDTH`, default 64: beat data width.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-low (asserted when 0).
- `wb_req`  in  1  level; MEMSync is in WriteBack.
- `alloc_req`  in  1  level; MEMSync is in Allocate.
- `cRowId`  in  CHWIDTH  cache row being filled or evicted.
- `RowId`  in  ADDRWIDTH  backing row to fetch on allocate.
- `wbRowId`  in  ADDRWIDTH  backing row of the victim on writeback.
- `sync`  out  1  one-cycle completion pulse to MEMSync.
- `busy`  out  1  high from transfer start through the sync cycle.
- `c_addr`  out  CHWIDTH+COLWIDTH  cache address {cRowId, col}.
- `c_rd`, `c_wr`  out  1  cache read/write strobes.
- `c_wdata`  out  DWIDTH  cache write data.
- `c_rdata`  in  DWIDTH  cache read data, valid the cycle after `c_rd`.
- `m_addr`  out  ADDRWIDTH+COLWIDTH  backing address {row, col}.
- `m_req`, `m_we`  out  1  backing request and write-enable.
- `m_ready`  in  1  backing accepts the request when `m_req & m_ready`.
- `m_wdata`  out  DWIDTH  backing write data.
- `m_rdata`  in  DWIDTH  backing read data, valid the cycle after an accepted read.

## Operation
- States: IDLE, AL_RD, AL_WR, WB_RD, WB_WR, DONE, HOLD.
- IDLE: both requests are sampled. `wb_req` has priority if both are high, which is a protocol violation. Row and cache indices are latched and col is cleared to 0.
- Allocate beat:
  - AL_RD drives `m_req=1`, `m_we=0`, `m_addr={RowId_l,col}` and holds until `m_ready`.
  - AL_WR drives `c_wr=1`, `c_addr={cRowId_l,col}`, `c_wdata=m_rdata`.
- Writeback beat:
  - WB_RD drives `c_rd=1` for one cycle.
  - WB_WR drives `m_req=1`, `m_we=1`, `m_wdata=c_rdata` (registered), `m_addr={wbRowId_l,col}` and holds until `m_ready`.
- After each write beat, col increments. Once col reaches COLS-1, the engine goes to DONE instead of wrapping.
- DONE: `sync=1` for exactly one cycle, then HOLD.
- HOLD: requests are ignored for one cycle, because MEMSync drops its request the cycle after `sync`. Next state is IDLE.
- Writeback followed by allocate: IDLE sees `alloc_req` after HOLD and starts the allocate with no extra handshake.
- Request deasserted mid-transfer: ignored. The transfer always completes.

## Timing
- Reset values: every output is 0; state IDLE; col 0; latched indices 0.
- Reset mid-transfer: abort immediately. No `sync` is emitted, and partially copied data is left as is.
- Allocate with `m_ready` tied high:
  - Request high in cycle 0 → AL_RD in cycle 1.
  - Each beat takes 2 cycles.
  - `sync` is high in cycle 2·COLS+1 (cycle 65 at defaults).
  - `busy` is high in cycles 1..2·COLS+1.
- Writeback takes the same count: 2·COLS+1.
- Each cycle with `m_ready=0` adds one cycle. During such a stall, `m_addr`, `m_we`, `m_wdata` and `m_req` stay stable.
- Back-to-back requests: the minimum gap between a `sync` pulse and the next transfer start is 2 cycles (HOLD, then IDLE).
- `c_rd`/`c_wr` and `m_req` are never high in the same cycle.

## Configuration
- `ROWSYNC_CNT_EN` defined:
  - Adds outputs `wb_cnt` and `al_cnt`, 32 bits each.
  - Each increments on the `sync` of its transfer type and wraps at 2^32.
  - Both reset to 0.
  - Also adds `stall_cnt` (32 bits), counting `m_req & ~m_ready` cycles.
- `ROWSYNC_CNT_EN` undefined: the three outputs are present but tied to 0, and no counter logic is generated.

## Structure
- `memsync_pkg` holds:
  - the state enum `rowsync_state_t`;
  - localparam COLS;
  - the shared MEMSync state encodings (Idle=0, Allocate=1, CompareTag=2, UpdateTag=3, WriteBack=4, hitRD=5, hitWR=6), so benches can cross-check.
- No sub-module. The column counter and FSM are one always_ff block with a combinational output decode.

## Test plan
- Reset: hold `rst=0` for 2 cycles with requests high → all outputs 0, no `sync`.
- Allocate, COLWIDTH=2, `m_ready=1`, `m_rdata=col+0x10`, RowId=0x1ABCD, cRowId=5 → 4 cache writes to addresses {5,0..3} with data 0x10..0x13; `sync` pulses in cycle 9.
- Writeback, cRowId=3, wbRowId=0x00042, `c_rdata=0xA0+col` → 4 backing writes to {0x42,0..3} with data 0xA0..0xA3; `sync` in cycle 9.
- Backpressure: `m_ready=0` for 3 cycles in beat 1 → outputs stable during the stall; `sync` moves to cycle 12.
- WriteBack→Allocate: `wb_req` held until `sync`, then `alloc_req` asserted → allocate starts 2 cycles after the first `sync`; exactly two `sync` pulses total.
- Reset asserted in cycle 4 of an allocate → outputs 0 next cycle, no `sync`; a new request after reset completes normally.
